// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and constants for the next-PC sequencer
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SHADOW = 2'd2
    } pc_seq_state_t;

    localparam int          PC_INC             = 4;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;
    localparam int          SHADOW_CNT_W       = 3;

endpackage

// File: rtl/pc_redirect_sel.sv
// rtl/pc_redirect_sel.sv - redirect request and priority target select (jr > jump > branch), word aligned
module pc_redirect_sel
    import pc_seq_pkg::*;
#(
    parameter int N_BITS = 32
) (
    input  logic              branch_taken_i,
    input  logic [N_BITS-1:0] branch_target_i,
    input  logic              jump_i,
    input  logic [N_BITS-1:0] jump_target_i,
    input  logic              jr_i,
    input  logic [N_BITS-1:0] jr_target_i,
    output logic              req_o,
    output logic [N_BITS-1:0] target_o
);

    logic [N_BITS-1:0] raw_target;

    assign req_o = jr_i | jump_i | branch_taken_i;

    always_comb begin
        raw_target = branch_target_i;
        if (jr_i) begin
            raw_target = jr_target_i;
        end else if (jump_i) begin
            raw_target = jump_target_i;
        end
        target_o = raw_target & ~N_BITS'(3);
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC sequencer with stall deferral and shadow window; optional PC_SEQ_EXC_EN
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                N_BITS        = 32,
    parameter int                SHADOW_CYCLES = 1,
    parameter logic [N_BITS-1:0] EXC_VECTOR    = N_BITS'(EXC_VECTOR_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_BITS-1:0] pc_value_i,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [N_BITS-1:0] branch_target_i,
    input  logic              jump_i,
    input  logic [N_BITS-1:0] jump_target_i,
    input  logic              jr_i,
    input  logic [N_BITS-1:0] jr_target_i,
`ifdef PC_SEQ_EXC_EN
    input  logic              exception_i,
    output logic [N_BITS-1:0] epc_o,
`endif
    output logic [N_BITS-1:0] new_pc_o,
    output logic              flush_o,
    output logic              busy_o
);

    localparam logic [SHADOW_CNT_W-1:0] SHADOW_LOAD = SHADOW_CNT_W'(SHADOW_CYCLES);

    pc_seq_state_t           state;
    logic [N_BITS-1:0]       pend_target;
    logic [SHADOW_CNT_W-1:0] shadow_cnt;
    logic                    req;
    logic [N_BITS-1:0]       sel_target;
    logic [N_BITS-1:0]       pc_inc;
    logic                    exc;

`ifdef PC_SEQ_EXC_EN
    assign exc = exception_i;
`else
    assign exc = 1'b0;
`endif

    assign pc_inc = pc_value_i + N_BITS'(PC_INC);

    pc_redirect_sel #(.N_BITS(N_BITS)) u_sel (
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .jr_i            (jr_i),
        .jr_target_i     (jr_target_i),
        .req_o           (req),
        .target_o        (sel_target)
    );

    // Only RUN reacts to a fresh request; HOLD replays the captured one, SHADOW ignores all.
    always_comb begin
        new_pc_o = stall_i ? pc_value_i : pc_inc;
        flush_o  = 1'b0;
        case (state)
            ST_RUN: begin
                if (!stall_i && req) begin
                    new_pc_o = sel_target;
                    flush_o  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!stall_i) begin
                    new_pc_o = pend_target;
                    flush_o  = 1'b1;
                end
            end
            default: ;
        endcase
        if (exc) begin
            new_pc_o = EXC_VECTOR;
            flush_o  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_RUN;
            pend_target <= '0;
            shadow_cnt  <= '0;
            busy_o      <= 1'b0;
        end else if (exc) begin
            state       <= ST_SHADOW;
            pend_target <= '0;
            shadow_cnt  <= SHADOW_LOAD;
            busy_o      <= 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (req && !stall_i) begin
                        state      <= ST_SHADOW;
                        shadow_cnt <= SHADOW_LOAD;
                        busy_o     <= 1'b1;
                    end else if (req) begin
                        state       <= ST_HOLD;
                        pend_target <= sel_target;
                        busy_o      <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!stall_i) begin
                        state      <= ST_SHADOW;
                        shadow_cnt <= SHADOW_LOAD;
                        busy_o     <= 1'b1;
                    end
                end
                ST_SHADOW: begin
                    if (!stall_i) begin
                        if (shadow_cnt <= SHADOW_CNT_W'(1)) begin
                            state      <= ST_RUN;
                            shadow_cnt <= '0;
                            busy_o     <= 1'b0;
                        end else begin
                            shadow_cnt <= shadow_cnt - SHADOW_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= ST_RUN;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_SEQ_EXC_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epc_o <= '0;
        end else if (exception_i) begin
            epc_o <= pc_value_i;
        end
    end
`endif

    redirect_onehot: assert property (@(posedge clk) disable iff (!reset)
        $onehot0({jr_i, jump_i, branch_taken_i}));

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic [31:0] pc_value_i;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic        jr_i;
    logic [31:0] jr_target_i;
    logic [31:0] new_pc_o;
    logic        flush_o;
    logic        busy_o;
`ifdef PC_SEQ_EXC_EN
    logic        exception_i;
    logic [31:0] epc_o;
`endif

    int total;
    int bad;

    pc_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .pc_value_i      (pc_value_i),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .jr_i            (jr_i),
        .jr_target_i     (jr_target_i),
`ifdef PC_SEQ_EXC_EN
        .exception_i     (exception_i),
        .epc_o           (epc_o),
`endif
        .new_pc_o        (new_pc_o),
        .flush_o         (flush_o),
        .busy_o          (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle(input logic [31:0] pc, input logic stall);
        pc_value_i     = pc;
        stall_i        = stall;
        branch_taken_i = 1'b0;
        jump_i         = 1'b0;
        jr_i           = 1'b0;
        branch_target_i = 32'h0;
        jump_target_i   = 32'h0;
        jr_target_i     = 32'h0;
`ifdef PC_SEQ_EXC_EN
        exception_i    = 1'b0;
`endif
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        idle(32'h0040_0000, 1'b0);
        #3;
        check("rst_busy", {31'b0, busy_o}, 32'h0);
        check("rst_newpc", new_pc_o, 32'h0040_0004);
        check("rst_flush", {31'b0, flush_o}, 32'h0);
        next_cycle();
        reset = 1'b1;

        // sequential after reset
        #2;
        check("seq_newpc", new_pc_o, 32'h0040_0004);
        check("seq_flush", {31'b0, flush_o}, 32'h0);
        check("seq_busy", {31'b0, busy_o}, 32'h0);
        next_cycle();

        // taken branch
        idle(32'h0040_0010, 1'b0);
        branch_taken_i = 1'b1; branch_target_i = 32'h0040_0100;
        #2;
        check("br_newpc", new_pc_o, 32'h0040_0100);
        check("br_flush", {31'b0, flush_o}, 32'h1);
        next_cycle();

        // wrong-path jump in shadow is ignored
        idle(32'h0040_0100, 1'b0);
        jump_i = 1'b1; jump_target_i = 32'h0040_0800;
        #2;
        check("shadow_newpc", new_pc_o, 32'h0040_0104);
        check("shadow_flush", {31'b0, flush_o}, 32'h0);
        check("shadow_busy", {31'b0, busy_o}, 32'h1);
        next_cycle();

        idle(32'h0040_0104, 1'b0);
        #2;
        check("post_shadow_busy", {31'b0, busy_o}, 32'h0);
        check("post_shadow_newpc", new_pc_o, 32'h0040_0108);
        next_cycle();

        // stall capture of a misaligned jr target
        idle(32'h0040_0020, 1'b1);
        jr_i = 1'b1; jr_target_i = 32'h0040_0203;
        #2;
        check("cap_newpc", new_pc_o, 32'h0040_0020);
        check("cap_flush", {31'b0, flush_o}, 32'h0);
        next_cycle();

        for (int i = 0; i < 3; i++) begin
            idle(32'h0040_0020, 1'b1);
            branch_taken_i = 1'b1; branch_target_i = 32'h0040_0500;
            #2;
            check("hold_newpc", new_pc_o, 32'h0040_0020);
            check("hold_flush", {31'b0, flush_o}, 32'h0);
            check("hold_busy", {31'b0, busy_o}, 32'h1);
            next_cycle();
        end

        idle(32'h0040_0020, 1'b0);
        #2;
        check("release_newpc", new_pc_o, 32'h0040_0200);
        check("release_flush", {31'b0, flush_o}, 32'h1);
        next_cycle();

        idle(32'h0040_0200, 1'b0);
        #2;
        check("release_shadow_newpc", new_pc_o, 32'h0040_0204);
        check("release_shadow_busy", {31'b0, busy_o}, 32'h1);
        next_cycle();

        // priority, applied and removed between clock edges
        idle(32'h0040_0204, 1'b0);
        jr_i = 1'b1; jr_target_i = 32'h0000_1000;
        jump_i = 1'b1; jump_target_i = 32'h0000_2000;
        branch_taken_i = 1'b1; branch_target_i = 32'h0000_3000;
        #2;
        check("prio_jr", new_pc_o, 32'h0000_1000);
        check("prio_flush", {31'b0, flush_o}, 32'h1);
        jr_i = 1'b0;
        #1;
        check("prio_jump", new_pc_o, 32'h0000_2000);
        idle(32'h0040_0204, 1'b0);
        next_cycle();

        // increment wraps
        idle(32'hFFFF_FFFC, 1'b0);
        #2;
        check("wrap_newpc", new_pc_o, 32'h0000_0000);
        check("wrap_busy", {31'b0, busy_o}, 32'h0);
        next_cycle();

        // reset while holding a deferred jump
        idle(32'h0040_0300, 1'b1);
        jump_i = 1'b1; jump_target_i = 32'h0040_0900;
        next_cycle();
        idle(32'h0040_0300, 1'b1);
        #2;
        check("hold2_busy", {31'b0, busy_o}, 32'h1);
        #1;
        reset = 1'b0;
        #1;
        check("async_rst_busy", {31'b0, busy_o}, 32'h0);
        next_cycle();
        reset = 1'b1;
        idle(32'h0040_0300, 1'b0);
        #2;
        check("no_pend_newpc", new_pc_o, 32'h0040_0304);
        check("no_pend_flush", {31'b0, flush_o}, 32'h0);
        next_cycle();
        #2;
        check("no_pend_busy", {31'b0, busy_o}, 32'h0);
        next_cycle();

`ifdef PC_SEQ_EXC_EN
        idle(32'h0040_0040, 1'b1);
        exception_i = 1'b1;
        #2;
        check("exc_newpc", new_pc_o, 32'h8000_0180);
        check("exc_flush", {31'b0, flush_o}, 32'h1);
        next_cycle();
        idle(32'h8000_0180, 1'b0);
        #2;
        check("exc_epc", epc_o, 32'h0040_0040);
        check("exc_busy", {31'b0, busy_o}, 32'h1);
        next_cycle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller that sequences the 32-bit program counter register.
- Each cycle it computes the value loaded into the PC: sequential increment, stall hold, or branch/jump/jr redirect.
- Defers a redirect that arrives during a stall and applies it when the stall drops.
- Suppresses wrong-path redirects for a programmable shadow window after a redirect.
- Sits between the pipeline control/ID stage and the PC register; its new_pc_o drives the PC's next-value input.

Parameters:
- N_BITS, 32, PC/target width.
- SHADOW_CYCLES, 1, non-stalled cycles after a redirect during which redirect inputs are ignored (range 1..7).
- EXC_VECTOR, 32'h80000180, exception handler address (used only with the optional feature).

Ports:
- clk  in  1  system clock; sequencer state updates on posedge (PC register loads on negedge).
- reset  in  1  asynchronous, active-low reset.
- pc_value_i  in  N_BITS  current PC register value.
- stall_i  in  1  hazard stall; hold PC.
- branch_taken_i  in  1  conditional branch resolved taken.
- branch_target_i  in  N_BITS  branch target.
- jump_i  in  1  j/jal.
- jump_target_i  in  N_BITS  jump target.
- jr_i  in  1  jr/jalr.
- jr_target_i  in  N_BITS  register target.
- new_pc_o  out  N_BITS  next PC value (combinational).
- flush_o  out  1  flush IF/ID this cycle (combinational).
- busy_o  out  1  state is HOLD or SHADOW (registered).

Behaviour:
- Reset (async, reset==0):
  - state=RUN, pend_target=0, shadow_cnt=0, busy_o=0.
  - new_pc_o=pc_value_i+4, flush_o=0 while inputs are idle.
- Redirect request: req = jr_i | jump_i | branch_taken_i.
- Target priority: jr > jump > branch.
- Targets have bits [1:0] forced to 0.
- Arithmetic: increment is pc_value_i+4 modulo 2^N_BITS; 32'hFFFFFFFC wraps to 0.
- RUN state:
  - !stall_i, !req: new_pc_o = pc+4.
  - !stall_i, req: new_pc_o = selected target, flush_o=1. Next state SHADOW, shadow_cnt=SHADOW_CYCLES.
  - stall_i, !req: new_pc_o = pc_value_i.
  - stall_i, req: new_pc_o = pc_value_i, flush_o=0. pend_target <= selected target, next state HOLD.
- HOLD state:
  - stall_i: new_pc_o = pc_value_i. New req ignored; the first captured redirect wins.
  - !stall_i: new_pc_o = pend_target, flush_o=1. Next state SHADOW, shadow_cnt=SHADOW_CYCLES.
- SHADOW state:
  - req ignored entirely (no flush, no capture).
  - !stall_i: new_pc_o = pc+4, shadow_cnt decrements; state goes to RUN when the count reaches 0.
  - stall_i: new_pc_o = pc_value_i, count frozen.
- busy_o = (state != RUN), registered.
- Latency: redirect applied in the same cycle as an unstalled req; PC reflects it at the next PC clock edge.
- Simultaneous jr/jump/branch is illegal: simulation-only assertion; the priority rule still applies.
- Reset mid-HOLD/SHADOW: pending target discarded, RUN immediately.

Optional Feature:
- Macro: PC_SEQ_EXC_EN.
- Defined: adds ports exception_i (in, 1) and epc_o (out, N_BITS, reset 0).
  - exception_i overrides every state, stall and shadow: new_pc_o=EXC_VECTOR, flush_o=1, epc_o <= pc_value_i.
  - Pending redirect is dropped; next state SHADOW with shadow_cnt=SHADOW_CYCLES.
- Undefined: ports absent; behaviour exactly as above.

Decomposition:
- Package pc_seq_pkg holds:
  - state typedef {RUN, HOLD, SHADOW} (2 bits);
  - PC_INC=4;
  - default EXC_VECTOR;
  - SHADOW counter width 3.
- One sub-module, pc_redirect_sel: combinational priority select plus alignment mask. Outputs req and target.

Test Plan:
- Sequential after reset: release reset with pc_value_i=0x400000, idle inputs -> new_pc_o=0x400004, flush_o=0, busy_o=0.
- Branch: pc=0x400010, branch_taken_i=1, target 0x400100 -> new_pc_o=0x400100, flush_o=1.
  - Next cycle: jump_i=1 target 0x400800 is ignored, new_pc_o=pc+4, busy_o=1.
  - Following cycle busy_o=0.
- Stall capture: stall_i=1 with jr_i=1 target 0x400203 (pc=0x400020) -> new_pc_o=0x400020, no flush.
  - Keep stall 3 cycles with branch_taken_i=1 target 0x400500 -> still holds.
  - Drop stall -> new_pc_o=0x400200, flush_o=1.
- Priority: jr_i, jump_i, branch_taken_i all 1 with targets 0x1000/0x2000/0x3000 -> new_pc_o=0x1000.
- Wrap and reset: pc=0xFFFFFFFC idle -> new_pc_o=0x00000000.
  - Assert reset in HOLD -> busy_o=0 immediately; after release, no pending redirect is applied.
- With PC_SEQ_EXC_EN: pc=0x400040, stall_i=1, exception_i=1 -> new_pc_o=0x80000180, flush_o=1, epc_o=0x400040 next edge.
